// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory: default geometry, the
// instruction word type, the NOP word and the default program image.
// Optional feature macro used by the memory top: IMEM_LOAD_EN (write port).
package imem_pkg;

  // Default geometry: 8 words of 32 bits.
  localparam int unsigned IMEM_ADDR_W = 3;
  localparam int unsigned IMEM_DATA_W = 32;

  // Number of words in the built-in program image.
  localparam int unsigned PROG_LEN = 8;

  typedef logic [31:0] instr_t;

  // All-zero word returned for reset and for addresses past the program.
  localparam instr_t NOP = 32'h0000_0000;

  // Default program, indexed by word address.
  localparam instr_t DEFAULT_PROG [PROG_LEN] = '{
    32'h2008_0005,  // 0
    32'h2009_000A,  // 1
    32'h0109_5020,  // 2
    32'h0149_5822,  // 3
    32'hAC0B_0000,  // 4
    32'h8C0C_0000,  // 5
    32'h118B_0001,  // 6
    32'h0800_0000   // 7
  };

  // Default word for any word address; beyond the program image the
  // memory holds NOP so no address ever returns undefined data.
  function automatic instr_t default_word(input int unsigned idx);
    instr_t w;
    w = NOP;
    if (idx < PROG_LEN) begin
      w = DEFAULT_PROG[idx[2:0]];
    end
    return w;
  endfunction

endpackage

// File: rtl/imem_default_rom.sv
// Combinational default-program lookup: maps a word address to its
// default instruction word (NOP beyond the program image).
// Ports: addr_i (word address in), word_o (default word out), no clock.
module imem_default_rom
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] word_o
);

  always_comb begin
    word_o = DATA_W'(default_word(32'(addr_i)));
  end

endmodule

// File: rtl/imem_rom.sv
// Instruction memory: 2^ADDR_W words, synchronous read with one cycle of
// latency, synchronous active-high reset that clears Instruction.
// Ports: clk, reset, Address -> Instruction; with IMEM_LOAD_EN defined also
// WriteEnable/WriteAddress/WriteData (register storage reloaded on reset).
// Without IMEM_LOAD_EN the storage is a constant ROM and reset only clears
// the output register.
module imem_rom
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Address,
`ifdef IMEM_LOAD_EN
  input  logic              WriteEnable,
  input  logic [ADDR_W-1:0] WriteAddress,
  input  logic [DATA_W-1:0] WriteData,
`endif
  output logic [DATA_W-1:0] Instruction
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] instr_d;

`ifdef IMEM_LOAD_EN

  // Default image for every address, used to reload the array on reset.
  logic [DATA_W-1:0] dflt_words [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dflt
    imem_default_rom #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_dflt (
      .addr_i (ADDR_W'(gi)),
      .word_o (dflt_words[gi])
    );
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // The read uses mem_q, so a same-edge write to the read address returns
  // the old word (read-before-write); reset wins over any write.
  always_comb begin
    mem_d   = mem_q;
    instr_d = mem_q[Address];
    if (reset) begin
      instr_d = DATA_W'(NOP);
      mem_d   = dflt_words;
    end else if (WriteEnable) begin
      mem_d[WriteAddress] = WriteData;
    end
  end

  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    mem_q   <= mem_d;
  end

`else

  logic [DATA_W-1:0] rom_word;

  imem_default_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .addr_i (Address),
    .word_o (rom_word)
  );

  always_comb begin
    instr_d = rom_word;
    if (reset) begin
      instr_d = DATA_W'(NOP);
    end
  end

  always_ff @(posedge clk) begin
    instr_q <= instr_d;
  end

`endif

  assign Instruction = instr_q;

endmodule

// File: tb/tb_imem_rom.sv
// Bench for imem_rom: directed program-image checks plus randomized traffic
// compared every cycle against a word-array model of the memory.
// Build with IMEM_LOAD_EN defined to also exercise the write port.
module tb_imem_rom;

  localparam int AW = 3;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic [AW-1:0] Address;
  logic [DW-1:0] Instruction;
`ifdef IMEM_LOAD_EN
  logic          WriteEnable;
  logic [AW-1:0] WriteAddress;
  logic [DW-1:0] WriteData;
`endif

  imem_rom #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .Address      (Address),
`ifdef IMEM_LOAD_EN
    .WriteEnable  (WriteEnable),
    .WriteAddress (WriteAddress),
    .WriteData    (WriteData),
`endif
    .Instruction  (Instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Program image written out independently of the design package.
  logic [31:0] prog [8];
  initial begin
    prog[0] = 32'h20080005; prog[1] = 32'h2009000A;
    prog[2] = 32'h01095020; prog[3] = 32'h01495822;
    prog[4] = 32'hAC0B0000; prog[5] = 32'h8C0C0000;
    prog[6] = 32'h118B0001; prog[7] = 32'h08000000;
  end

  // Model: memory contents and the word the output must show.
  logic [31:0] model_mem [8];
  logic [31:0] exp_instr;
  bit          started = 0;
  bit          done    = 0;

  always @(posedge clk) begin
    if (reset) begin
      exp_instr = 32'h0;
`ifdef IMEM_LOAD_EN
      for (int k = 0; k < 8; k++) model_mem[k] = prog[k];
`endif
    end else begin
      exp_instr = model_mem[Address];
`ifdef IMEM_LOAD_EN
      if (WriteEnable) model_mem[WriteAddress] = WriteData;
`endif
    end
    started = 1;
  end

  // Continuous compare, half a cycle after each edge.
  always @(negedge clk) begin
    if (started && !done) begin
      total++;
      if (Instruction !== exp_instr) begin
        bad++;
        $display("FAIL model t=%0t addr=%0d got=%h want=%h", $time, Address, Instruction, exp_instr);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] want);
    total++;
    if (Instruction !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, Instruction, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) model_mem[k] = 32'h0;
    #0;
    for (int k = 0; k < 8; k++) model_mem[k] = prog[k];
    reset   = 1'b1;
    Address = '0;
`ifdef IMEM_LOAD_EN
    WriteEnable  = 1'b0;
    WriteAddress = '0;
    WriteData    = '0;
`endif

    step(); step();
    check("reset_zero", 32'h0);

    reset = 1'b0; Address = 3'd0;
    step();
    check("first_fetch", 32'h20080005);

    for (int a = 0; a < 8; a++) begin
      Address = AW'(a);
      step();
      check($sformatf("sweep%0d", a), prog[a]);
    end

    Address = 3'd3;
    for (int n = 0; n < 5; n++) begin
      step();
      check("hold3", 32'h01495822);
    end

    Address = 3'd4; step();
    check("pre_reset4", 32'hAC0B0000);
    Address = 3'd5; reset = 1'b1; step();
    check("mid_reset", 32'h0);
    reset = 1'b0; step();
    check("after_reset5", 32'h8C0C0000);

`ifdef IMEM_LOAD_EN
    Address = 3'd2; WriteEnable = 1'b1; WriteAddress = 3'd2; WriteData = 32'hDEADBEEF;
    step();
    check("rbw_old", 32'h01095020);
    WriteEnable = 1'b0;
    step();
    check("rbw_new", 32'hDEADBEEF);
    reset = 1'b1; step();
    reset = 1'b0; step();
    check("reload2", 32'h01095020);
    Address = 3'd0; reset = 1'b1; WriteEnable = 1'b1; WriteAddress = 3'd0; WriteData = 32'h12345678;
    step();
    reset = 1'b0; WriteEnable = 1'b0;
    step();
    check("reset_beats_write", 32'h20080005);
`endif

    for (int n = 0; n < 400; n++) begin
      Address = AW'($urandom_range(0, 7));
      reset   = ($urandom_range(0, 24) == 0);
`ifdef IMEM_LOAD_EN
      WriteEnable  = ($urandom_range(0, 2) == 0);
      WriteAddress = AW'($urandom_range(0, 7));
      WriteData    = $urandom;
`endif
      step();
    end

    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
